// File: rtl/prog_loader_pkg.sv
// Shared program-memory constants and loader FSM state encoding.
package prog_loader_pkg;

  localparam int PM_WIDTH      = 12;
  localparam int PM_DEPTH      = 256;
  localparam int PM_ADDR_WIDTH = 8;
  localparam int CSUM_WIDTH    = 8;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_COUNT_LO,
    LD_COUNT_HI,
    LD_WORD_LO,
    LD_WORD_HI,
    LD_CHECK,
    LD_DONE,
    LD_ERROR
  } ld_state_e;

  function automatic logic takes_byte(ld_state_e s);
    return (s == LD_COUNT_LO) || (s == LD_COUNT_HI) ||
           (s == LD_WORD_LO)  || (s == LD_WORD_HI)  ||
           (s == LD_CHECK);
  endfunction

endpackage

// File: rtl/prog_loader_rx_frame.sv
// Byte-stream framing FSM: word count, word assembly and checksum.
module prog_loader_rx_frame
  import prog_loader_pkg::*;
#(
  parameter int DEPTH = PM_DEPTH,
  parameter int WIDTH = PM_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_i,
  input  logic [7:0]       rx_data_i,
  input  logic             rx_valid_i,
  output logic             rx_ready_o,
  output logic             start_ok_o,
  output logic             word_valid_o,
  output logic [WIDTH-1:0] word_data_o,
  output logic             frame_ok_o,
  output logic             frame_err_o
);

  ld_state_e             state_q, state_d;
  logic                  rx_ready_q;
  logic [7:0]            cnt_lo_q, cnt_lo_d;
  logic [15:0]           remain_q, remain_d;
  logic [CSUM_WIDTH-1:0] sum_q, sum_d;
  logic [7:0]            lo_q, lo_d;

  logic                  accept;
  logic [CSUM_WIDTH-1:0] sum_nx;
  logic [15:0]           count;

  assign accept = rx_valid_i && rx_ready_q;
  assign sum_nx = sum_q + rx_data_i;
  assign count  = {rx_data_i, cnt_lo_q};

  always_comb begin
    state_d      = state_q;
    cnt_lo_d     = cnt_lo_q;
    remain_d     = remain_q;
    sum_d        = sum_q;
    lo_d         = lo_q;
    start_ok_o   = 1'b0;
    word_valid_o = 1'b0;
    unique case (state_q)
      LD_IDLE: begin
        if (start_i) begin
          state_d    = LD_COUNT_LO;
          sum_d      = '0;
          start_ok_o = 1'b1;
        end
      end
      LD_COUNT_LO: begin
        if (accept) begin
          cnt_lo_d = rx_data_i;
          sum_d    = sum_nx;
          state_d  = LD_COUNT_HI;
        end
      end
      LD_COUNT_HI: begin
        if (accept) begin
          sum_d    = sum_nx;
          remain_d = count;
          if (count > 16'(DEPTH))
            state_d = LD_ERROR;
          else if (count == 16'd0)
            state_d = LD_CHECK;
          else
            state_d = LD_WORD_LO;
        end
      end
      LD_WORD_LO: begin
        if (accept) begin
          lo_d    = rx_data_i;
          sum_d   = sum_nx;
          state_d = LD_WORD_HI;
        end
      end
      LD_WORD_HI: begin
        if (accept) begin
          sum_d = sum_nx;
          if (rx_data_i[7:4] != 4'd0) begin
            state_d = LD_ERROR;
          end else begin
            word_valid_o = 1'b1;
            remain_d     = remain_q - 16'd1;
            state_d      = (remain_q == 16'd1) ? LD_CHECK : LD_WORD_LO;
          end
        end
      end
      LD_CHECK: begin
        if (accept)
          state_d = (sum_nx == '0) ? LD_DONE : LD_ERROR;
      end
      LD_DONE:  state_d = LD_IDLE;
      LD_ERROR: state_d = LD_IDLE;
      default:  state_d = LD_IDLE;
    endcase
  end

  assign word_data_o = {rx_data_i[WIDTH-9:0], lo_q};
  assign frame_ok_o  = (state_q == LD_CHECK) && (state_d == LD_DONE);
  assign frame_err_o = (state_q != LD_ERROR) && (state_d == LD_ERROR);
  assign rx_ready_o  = rx_ready_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= LD_IDLE;
      rx_ready_q <= 1'b0;
      cnt_lo_q   <= '0;
      remain_q   <= '0;
      sum_q      <= '0;
      lo_q       <= '0;
    end else begin
      state_q    <= state_d;
      rx_ready_q <= takes_byte(state_d);
      cnt_lo_q   <= cnt_lo_d;
      remain_q   <= remain_d;
      sum_q      <= sum_d;
      lo_q       <= lo_d;
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Program RAM loader: frames a byte stream into the RAM write port.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = PM_ADDR_WIDTH,
  parameter int DEPTH      = PM_DEPTH,
  parameter int WIDTH      = PM_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0]      mem_data,
  output logic                  mem_wren,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   words_written
);

  logic             start_ok, word_valid, frame_ok, frame_err;
  logic [WIDTH-1:0] word_data;

  prog_loader_rx_frame #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_frame (
    .clock        (clock),
    .reset        (reset),
    .start_i      (start),
    .rx_data_i    (rx_data),
    .rx_valid_i   (rx_valid),
    .rx_ready_o   (rx_ready),
    .start_ok_o   (start_ok),
    .word_valid_o (word_valid),
    .word_data_o  (word_data),
    .frame_ok_o   (frame_ok),
    .frame_err_o  (frame_err)
  );

  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0]      data_q, data_d;
  logic                  wren_q, wren_d;
  logic                  hold_q, hold_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;

  // words_q doubles as the address counter; count <= DEPTH keeps it in range
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    wren_d  = 1'b0;
    hold_d  = hold_q;
    busy_d  = busy_q;
    done_d  = done_q;
    err_d   = err_q;
    words_d = words_q;
    if (start_ok) begin
      done_d  = 1'b0;
      err_d   = 1'b0;
      words_d = '0;
      hold_d  = 1'b1;
      busy_d  = 1'b1;
    end
    if (word_valid) begin
      wren_d  = 1'b1;
      addr_d  = words_q[ADDR_WIDTH-1:0];
      data_d  = word_data;
      words_d = words_q + (ADDR_WIDTH+1)'(1);
    end
    if (frame_ok) begin
      done_d = 1'b1;
      busy_d = 1'b0;
      hold_d = 1'b0;
    end
    if (frame_err) begin
      err_d  = 1'b1;
      busy_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      data_q  <= '0;
      wren_q  <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      words_q <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      wren_q  <= wren_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      words_q <= words_d;
    end
  end

  assign mem_addr      = addr_q;
  assign mem_data      = data_q;
  assign mem_wren      = wren_q;
  assign cpu_hold      = hold_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = err_q;
  assign words_written = words_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a write-port scoreboard.
module tb_prog_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] mem_addr;
  logic [11:0] mem_data;
  logic       mem_wren;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic       error;
  logic [8:0] words_written;

  int n_checks = 0;
  int n_fail   = 0;

  logic [19:0] exp_q[$];
  logic [11:0] img[$];

  prog_loader dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .rx_data       (rx_data),
    .rx_valid      (rx_valid),
    .rx_ready      (rx_ready),
    .mem_addr      (mem_addr),
    .mem_data      (mem_data),
    .mem_wren      (mem_wren),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .words_written (words_written)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write cycle must match the oldest expected write
  always @(negedge clock) begin
    if (!reset && mem_wren) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wren", {mem_addr, mem_data}, 20'hxxxxx);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e[19:12]);
        chk("wr_data", mem_data, e[11:0]);
        chk("wr_count", words_written, e[19:12] + 9'd1);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("rx_ready_wait", rx_ready, 1);
    @(posedge clock);
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  // Sends img as a frame; csum_delta corrupts the checksum byte
  task automatic send_image(input logic [7:0] csum_delta);
    logic [7:0]  s;
    logic [15:0] cnt;
    s   = 8'd0;
    cnt = 16'(img.size());
    send_byte(cnt[7:0]);
    s += cnt[7:0];
    send_byte(cnt[15:8]);
    s += cnt[15:8];
    for (int i = 0; i < img.size(); i++) begin
      logic [7:0] lo, hi;
      lo = img[i][7:0];
      hi = {4'd0, img[i][11:8]};
      send_byte(lo);
      s += lo;
      exp_q.push_back({8'(i), img[i]});
      send_byte(hi);
      s += hi;
    end
    send_byte(8'(8'd0 - s) + csum_delta);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    #3;
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_wren", mem_wren, 0);
    chk("rst_hold", cpu_hold, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data", mem_data, 0);
    chk("rst_words", words_written, 0);
    cycles(2);
    reset = 1'b0;
    cycles(2);

    // Nominal two-word load
    pulse_start();
    chk("nom_busy", busy, 1);
    chk("nom_hold", cpu_hold, 1);
    chk("nom_ready", rx_ready, 1);
    img = '{12'h134, 12'hACD};
    send_image(8'd0);
    chk("nom_done", done, 1);
    chk("nom_error", error, 0);
    chk("nom_busy_end", busy, 0);
    chk("nom_hold_end", cpu_hold, 0);
    chk("nom_ready_end", rx_ready, 0);
    chk("nom_words", words_written, 2);
    cycles(3);
    chk("nom_done_sticky", done, 1);
    chk("nom_sb_empty", exp_q.size(), 0);

    // Same image, checksum off by one
    pulse_start();
    chk("bad_done_clr", done, 0);
    send_image(8'd1);
    chk("bad_error", error, 1);
    chk("bad_done", done, 0);
    chk("bad_hold", cpu_hold, 1);
    chk("bad_busy", busy, 0);
    chk("bad_words", words_written, 2);
    cycles(3);
    chk("bad_err_sticky", error, 1);
    chk("bad_hold_sticky", cpu_hold, 1);
    chk("bad_sb_empty", exp_q.size(), 0);

    // Count 257 exceeds depth
    pulse_start();
    chk("ovr_err_clr", error, 0);
    chk("ovr_words_clr", words_written, 0);
    send_byte(8'h01);
    send_byte(8'h01);
    chk("ovr_error", error, 1);
    chk("ovr_ready", rx_ready, 0);
    chk("ovr_hold", cpu_hold, 1);
    cycles(3);
    chk("ovr_ready_late", rx_ready, 0);

    // Illegal high nibble on the only word
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'hF0);
    chk("nib_error", error, 1);
    chk("nib_words", words_written, 0);
    chk("nib_wren", mem_wren, 0);
    cycles(3);

    // Zero count with stalls between bytes
    pulse_start();
    for (int b = 0; b < 3; b++) begin
      send_byte(8'h00);
      if (b < 2) begin
        for (int k = 0; k < 5; k++) begin
          chk("stall_ready", rx_ready, 1);
          chk("stall_busy", busy, 1);
          cycles(1);
        end
      end
    end
    chk("zero_done", done, 1);
    chk("zero_error", error, 0);
    chk("zero_words", words_written, 0);
    chk("zero_hold", cpu_hold, 0);
    cycles(3);

    // Start mid-frame must not restart the count
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    pulse_start();
    exp_q.push_back({8'd0, 12'h134});
    send_byte(8'h01);
    send_byte(8'hCD);
    exp_q.push_back({8'd1, 12'hACD});
    send_byte(8'h0A);
    send_byte(8'hF2);
    chk("restart_done", done, 1);
    chk("restart_words", words_written, 2);
    chk("restart_sb_empty", exp_q.size(), 0);
    cycles(3);

    // Asynchronous reset mid-word
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    send_byte(8'h34);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_hold", cpu_hold, 0);
    chk("arst_ready", rx_ready, 0);
    chk("arst_done", done, 0);
    chk("arst_error", error, 0);
    chk("arst_words", words_written, 0);
    chk("arst_wren", mem_wren, 0);
    cycles(2);
    reset = 1'b0;
    cycles(3);
    chk("final_sb_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
